// File: rtl/cla16_pkg.sv
// cla16_pkg
// Shared constants and types for the 16-bit carry-lookahead adder and the
// array multiplier that reuses it as its final carry-propagate stage.
//   WIDTH   : operand / sum width (only 16 is supported)
//   GROUP   : bits per lookahead group
//   NGROUPS : number of lookahead groups (WIDTH / GROUP)
package cla16_pkg;

    localparam int WIDTH   = 16;
    localparam int GROUP   = 4;
    localparam int NGROUPS = WIDTH / GROUP;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [GROUP-1:0] nibble_t;

endpackage : cla16_pkg

// File: rtl/full_adder.sv
// full_adder
// One-bit full adder. In cla16_adder it only forms the sum bit (the carry
// comes from the lookahead network); the multiplier's carry-save rows use
// both outputs.
// Ports:
//   a, b, cin : input bits
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/cla16_adder.sv
// cla16_adder
// Registered 16-bit unsigned carry-lookahead adder: {c16, sum} = a + b + c0.
// A two-level lookahead core (4 groups of 4 bits) feeds one output register.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous reset, active-high (clears outputs, drops valid)
//   in_valid  : a, b, c0 are meaningful this cycle
//   a, b      : 16-bit unsigned addends
//   c0        : carry-in
//   out_valid : sum / c16 carry a fresh result
//   sum       : registered (a + b + c0) mod 2^16
//   c16       : registered carry-out
//
// Handshake: valid-only, no ready. An operation is accepted on every rising
// edge where in_valid=1 and rst=0; its result is presented on the following
// cycle with out_valid=1. When in_valid=0 out_valid drops but sum/c16 keep
// their last value. rst wins over in_valid and discards that operation.
module cla16_adder
    import cla16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c0,
    output logic        out_valid,
    output logic [15:0] sum,
    output logic        c16
);

    word_t              g;        // per-bit generate
    word_t              p;        // per-bit propagate
    word_t              c;        // carry into each bit
    logic [NGROUPS-1:0] grp_g;    // group generate
    logic [NGROUPS-1:0] grp_p;    // group propagate
    logic [NGROUPS:0]   gc;       // group carry-ins c0, c4, c8, c12, c16

    word_t              sum_d;
    logic               c16_d;
    word_t              fa_cout_unused;

    word_t              sum_q;
    logic               c16_q;
    logic               valid_q;

    always_comb begin
        g = a & b;
        p = a ^ b;

        // First level: group generate / propagate per nibble.
        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < NGROUPS; k++) begin
            grp_g[k] = g[k*GROUP+3]
                     | (p[k*GROUP+3] & g[k*GROUP+2])
                     | (p[k*GROUP+3] & p[k*GROUP+2] & g[k*GROUP+1])
                     | (p[k*GROUP+3] & p[k*GROUP+2] & p[k*GROUP+1] & g[k*GROUP]);
            grp_p[k] = p[k*GROUP+3] & p[k*GROUP+2] & p[k*GROUP+1] & p[k*GROUP];
        end

        // Second level: every group carry-in straight from G, P and c0, so no
        // carry waits on a neighbouring group.
        gc[0] = c0;
        gc[1] = grp_g[0]
              | (grp_p[0] & c0);
        gc[2] = grp_g[1]
              | (grp_p[1] & grp_g[0])
              | (grp_p[1] & grp_p[0] & c0);
        gc[3] = grp_g[2]
              | (grp_p[2] & grp_g[1])
              | (grp_p[2] & grp_p[1] & grp_g[0])
              | (grp_p[2] & grp_p[1] & grp_p[0] & c0);
        gc[4] = grp_g[3]
              | (grp_p[3] & grp_g[2])
              | (grp_p[3] & grp_p[2] & grp_g[1])
              | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
              | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & c0);

        // Carries inside each group, expanded from the group carry-in.
        c = '0;
        for (int k = 0; k < NGROUPS; k++) begin
            c[k*GROUP]   = gc[k];
            c[k*GROUP+1] = g[k*GROUP]
                         | (p[k*GROUP] & gc[k]);
            c[k*GROUP+2] = g[k*GROUP+1]
                         | (p[k*GROUP+1] & g[k*GROUP])
                         | (p[k*GROUP+1] & p[k*GROUP] & gc[k]);
            c[k*GROUP+3] = g[k*GROUP+2]
                         | (p[k*GROUP+2] & g[k*GROUP+1])
                         | (p[k*GROUP+2] & p[k*GROUP+1] & g[k*GROUP])
                         | (p[k*GROUP+2] & p[k*GROUP+1] & p[k*GROUP] & gc[k]);
        end

        c16_d = gc[NGROUPS];
    end

    // Sum bits; the adders' own carry-out is redundant with the lookahead.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum_d[i]),
            .cout (fa_cout_unused[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            c16_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q <= sum_d;
                c16_q <= c16_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign sum       = sum_q;
    assign c16       = c16_q;

endmodule : cla16_adder

// File: tb/tb_cla16_adder.sv
// tb_cla16_adder
// Self-checking bench for cla16_adder. Expected results come from plain
// 17-bit integer addition kept in an expected queue.
module tb_cla16_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        c0;
    logic        out_valid;
    logic [15:0] sum;
    logic        c16;

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_q[$];

    cla16_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c0        (c0),
        .out_valid (out_valid),
        .sum       (sum),
        .c16       (c16)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic v, input logic [15:0] av,
                         input logic [15:0] bv, input logic cv);
        rst      = r;
        in_valid = v;
        a        = av;
        b        = bv;
        c0       = cv;
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] model(input logic [15:0] av,
                                         input logic [15:0] bv, input logic cv);
        return {1'b0, av} + {1'b0, bv} + {16'd0, cv};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b1, 1'b1, 16'h1234, 16'h1111, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || sum !== 16'h0000 || c16 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got v=%b sum=%h c16=%b, expected v=0 sum=0000 c16=0",
                         i, out_valid, sum, c16);
            end
        end
        drive(1'b0, 1'b1, 16'h1234, 16'h1111, 1'b0);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || {c16, sum} !== 17'h02345) begin
            errors++;
            $display("FAIL reset_release: got v=%b c16=%b sum=%h, expected v=1 c16=0 sum=2345",
                     out_valid, c16, sum);
        end
    endtask

    // Back-to-back directed vectors; each result checked one cycle later.
    task automatic test_directed(input string name, input logic [15:0] av[],
                                 input logic [15:0] bv[], input logic cv[],
                                 input logic [16:0] ev[]);
        for (int i = 0; i < av.size(); i++) begin
            drive(1'b0, 1'b1, av[i], bv[i], cv[i]);
            tick();
            checks++;
            if (out_valid !== 1'b1 || {c16, sum} !== ev[i]) begin
                errors++;
                $display("FAIL %s[%0d]: got v=%b c16=%b sum=%h, expected v=1 c16=%b sum=%h",
                         name, i, out_valid, c16, sum, ev[i][16], ev[i][15:0]);
            end
        end
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
    endtask

    task automatic test_basic();
        test_directed("basic", '{16'd30}, '{16'd500}, '{1'b0}, '{17'h00212});
    endtask

    task automatic test_back_to_back();
        test_directed("carry_chain", '{16'hFFFF, 16'hFFFF}, '{16'h0001, 16'hFFFF},
                      '{1'b0, 1'b1}, '{17'h10000, 17'h1FFFF});
        test_directed("wrap_cin", '{16'hFFFF}, '{16'h0000}, '{1'b1}, '{17'h10000});
    endtask

    task automatic test_group_boundaries();
        test_directed("group_bound", '{16'h000F, 16'h0FFF, 16'h7FFF, 16'h00FF},
                      '{16'h0001, 16'h0001, 16'h7FFF, 16'h0001},
                      '{1'b0, 1'b0, 1'b1, 1'b0},
                      '{17'h00010, 17'h01000, 17'h0FFFF, 17'h00100});
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, 16'd5, 16'd7, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b1 || {c16, sum} !== 17'd12) begin
            errors++;
            $display("FAIL hold_load: got v=%b c16=%b sum=%0d, expected v=1 c16=0 sum=12",
                     out_valid, c16, sum);
        end
        drive(1'b0, 1'b0, 16'hAAAA, 16'h5555, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || {c16, sum} !== 17'd12) begin
                errors++;
                $display("FAIL hold_idle[%0d]: got v=%b c16=%b sum=%0d, expected v=0 c16=0 sum=12",
                         i, out_valid, c16, sum);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        drive(1'b0, 1'b1, 16'h8000, 16'h8001, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b1 || {c16, sum} !== 17'h10001) begin
            errors++;
            $display("FAIL midrst_load: got v=%b c16=%b sum=%h, expected v=1 c16=1 sum=0001",
                     out_valid, c16, sum);
        end
        drive(1'b1, 1'b1, 16'h0009, 16'h0009, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || sum !== 16'h0000 || c16 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: got v=%b c16=%b sum=%h, expected v=0 c16=0 sum=0000",
                     out_valid, c16, sum);
        end
        drive(1'b0, 1'b0, 16'h0009, 16'h0009, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || sum !== 16'h0000 || c16 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_drop: got v=%b c16=%b sum=%h, expected v=0 c16=0 sum=0000",
                     out_valid, c16, sum);
        end
    endtask

    // Random operands and gaps; scoreboard pops one expected result per
    // accepted operation, idle cycles must hold the last result.
    task automatic test_random();
        logic [15:0] av;
        logic [15:0] bv;
        logic        cv;
        logic        v;
        logic        prev_v = 1'b0;
        logic [16:0] last_res = 17'd0;
        logic [16:0] exp_res;
        int          cyc_err = 0;
        exp_q.delete();
        for (int n = 0; n < 10000; n++) begin
            v  = ($urandom_range(0, 3) != 0);
            av = 16'($urandom_range(0, 65535));
            bv = 16'($urandom_range(0, 65535));
            cv = 1'($urandom_range(0, 1));
            if (n % 97 == 0) av = 16'hFFFF;
            if (v) exp_q.push_back(model(av, bv, cv));
            drive(1'b0, v, av, bv, cv);
            tick();
            prev_v = v;
            checks++;
            if (prev_v) begin
                exp_res  = exp_q.pop_front();
                last_res = exp_res;
            end else begin
                exp_res = last_res;
            end
            if (out_valid !== prev_v || {c16, sum} !== exp_res) begin
                errors++;
                cyc_err++;
                if (cyc_err <= 10)
                    $display("FAIL random[%0d]: got v=%b c16=%b sum=%h, expected v=%b c16=%b sum=%h",
                             n, out_valid, c16, sum, prev_v, exp_res[16], exp_res[15:0]);
            end
        end
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d left in queue, expected 0", exp_q.size());
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        test_reset();
        test_basic();
        test_back_to_back();
        test_group_boundaries();
        test_hold();
        test_reset_mid_stream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cla16_adder
